// File: rtl/fifo_pkg.sv
// Shared types and helpers for the asynchronous FIFO schedulers.
// Both the write-side and read-side arbiters import this package.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  localparam int FIFO_DSIZE = 8;
  localparam int ONEHOT_W   = 32;

  // Wide one-hot; callers cast it down to their requester count.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    onehot = '0;
    if (idx < ONEHOT_W) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr,
// wrapping modulo NREQ, built as a double-width masked priority encoder.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [2*NREQ-1:0] masked;

  // NOTE: every variable written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    masked = {req, req};
    for (int i = 0; i < NREQ; i++) begin
      if (i < int'(rr_ptr)) masked[i] = 1'b0;
    end
    // Scan downward so the last hit, i.e. the lowest masked position, wins.
    idx = '0;
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (masked[i]) idx = IW'(i % NREQ);
    end
    valid = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler: shares the FIFO write port among NREQ requesters with
// round-robin grants, bounded bursts and combinational wfull back-pressure.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = FIFO_DSIZE,
  parameter int MAX_BURST = 4,
  parameter int IW        = $clog2(NREQ),
  parameter int CW        = $clog2(MAX_BURST+1)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  input  logic                  wfull,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy,
  output logic [CW-1:0]         burst_cnt
);

  sched_state_e    state, state_next;
  logic [IW-1:0]   owner, owner_next;
  logic [IW-1:0]   rr_ptr, rr_ptr_next;
  logic [NREQ-1:0] gnt_next;
  logic [CW-1:0]   cnt_next;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            owner_req;
  logic            burst_end;
  logic [IW-1:0]   owner_succ;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign busy      = (state == BURST);
  assign owner_req = req[owner];
  assign wdata     = req_data[int'(owner)*DSIZE +: DSIZE];

  // wfull and wrst gate the strobe combinationally, so a write can never land
  // in a full FIFO or in a reset cycle.
  assign winc = busy & owner_req & ~wfull & ~wrst;
  assign ack  = winc ? NREQ'(onehot(int'(owner))) : '0;

  assign burst_end  = winc & (req_last[owner] | (burst_cnt == CW'(MAX_BURST-1)));
  assign owner_succ = (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    gnt_next    = gnt;
    cnt_next    = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_next = pick_idx;
          gnt_next   = NREQ'(onehot(int'(pick_idx)));
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        // A dropped request ends the grant just like a completed burst.
        if (!owner_req || burst_end) begin
          state_next  = IDLE;
          gnt_next    = '0;
          cnt_next    = '0;
          rr_ptr_next = owner_succ;
        end else if (winc) begin
          cnt_next = burst_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      rr_ptr    <= rr_ptr_next;
      gnt       <= gnt_next;
      burst_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario-driven bench for fifo_wr_arbiter: per-requester word queues feed the
// DUT, and an ordered scoreboard of (requester, data) is checked on every winc.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;
  localparam int IW        = 2;
  localparam int CW        = 3;
  localparam int DEPTH     = 32;

  logic                  wclk;
  logic                  wrst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic                  wfull;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;
  logic [CW-1:0]         burst_cnt;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST),
    .IW        (IW),
    .CW        (CW)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .wfull     (wfull),
    .gnt       (gnt),
    .ack       (ack),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester model: each requester holds its head word while it has data.
  logic [DSIZE:0] mem [NREQ][DEPTH];
  int head [NREQ];
  int tail [NREQ];

  // Expected writes in order: {requester index, data}.
  logic [IW+DSIZE-1:0] sb [$];

  logic [NREQ-1:0]  obs_gnt;
  logic [NREQ-1:0]  obs_ack;
  logic             obs_winc;
  logic             obs_busy;
  logic [CW-1:0]    obs_cnt;
  logic [DSIZE-1:0] obs_wdata;

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic put(input int r, input logic [DSIZE-1:0] d, input logic last);
    mem[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  task automatic expect_word(input int r, input logic [DSIZE-1:0] d);
    logic [IW-1:0] ri;
    ri = IW'(r);
    sb.push_back({ri, d});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i]) begin
        req[i]                     = 1'b1;
        req_data[i*DSIZE +: DSIZE] = mem[i][head[i]][DSIZE-1:0];
        req_last[i]                = mem[i][head[i]][DSIZE];
      end else begin
        req[i]                     = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
        req_last[i]                = 1'b0;
      end
    end
  endtask

  // Samples outputs mid-cycle and scores any write against the scoreboard.
  task automatic monitor();
    int                  ack_idx;
    int                  ones;
    logic [IW+DSIZE-1:0] exp_w;
    logic [IW-1:0]       ai;
    obs_gnt   = gnt;
    obs_ack   = ack;
    obs_winc  = winc;
    obs_busy  = busy;
    obs_cnt   = burst_cnt;
    obs_wdata = wdata;
    ack_idx   = -1;
    ones      = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        ack_idx = i;
        ones++;
      end
    end
    n_tests++;
    if (ack !== (winc ? gnt : '0)) begin
      n_fail++;
      $display("FAIL ack_vs_gnt: ack=%b winc=%b gnt=%b", ack, winc, gnt);
    end
    if (winc === 1'b1) begin
      n_tests++;
      if (ones != 1) begin
        n_fail++;
        $display("FAIL ack_onehot: ack=%b during write", ack);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: req=%0d data=%h, required no write", ack_idx, wdata);
      end else begin
        exp_w = sb.pop_front();
        ai    = IW'(ack_idx);
        if ({ai, wdata} !== exp_w) begin
          n_fail++;
          $display("FAIL write_order: got req=%0d data=%h, required req=%0d data=%h",
                   ack_idx, wdata, exp_w[IW+DSIZE-1:DSIZE], exp_w[DSIZE-1:0]);
        end
      end
      if (ack_idx >= 0 && head[ack_idx] != tail[ack_idx]) head[ack_idx]++;
    end
  endtask

  task automatic cycle();
    @(negedge wclk);
    monitor();
    @(posedge wclk);
    #1;
    drive();
  endtask

  task automatic check_sb_empty(input string name);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: %0d writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    wrst  = 1'b1;
    wfull = 1'b0;
    clear_queues();
    drive();
    cycle();
    cycle();
    n_tests++;
    if (obs_gnt !== '0 || obs_busy !== 1'b0 || obs_cnt !== '0 || obs_winc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b busy=%b cnt=%0d winc=%b, required 0/0/0/0",
               obs_gnt, obs_busy, obs_cnt, obs_winc);
    end
    wrst = 1'b0;
    cycle();
    n_tests++;
    if (obs_gnt !== '0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b busy=%b, required 0000/0", obs_gnt, obs_busy);
    end
  endtask

  // All four requesters busy and never marking last: rotation 0,1,2,3,0.
  task automatic test_fairness();
    logic [NREQ-1:0] exp_order [5];
    logic [NREQ-1:0] order [8];
    logic [NREQ-1:0] prev_gnt;
    int n_grants, idle_cnt, winc_cnt;
    logic [CW-1:0] max_cnt;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_queues();
    for (int k = 0; k < 8; k++) put(0, DSIZE'(8'h00 + k), 1'b0);
    for (int r = 1; r < NREQ; r++)
      for (int k = 0; k < 4; k++) put(r, DSIZE'(r*16 + k), 1'b0);
    for (int k = 0; k < 4; k++) expect_word(0, DSIZE'(8'h00 + k));
    for (int r = 1; r < NREQ; r++)
      for (int k = 0; k < 4; k++) expect_word(r, DSIZE'(r*16 + k));
    for (int k = 4; k < 8; k++) expect_word(0, DSIZE'(8'h00 + k));
    drive();
    prev_gnt = '0;
    n_grants = 0;
    idle_cnt = 0;
    winc_cnt = 0;
    max_cnt  = '0;
    for (int c = 0; c < 25; c++) begin
      cycle();
      if (!obs_busy) idle_cnt++;
      if (obs_winc) winc_cnt++;
      if (obs_winc && obs_cnt > max_cnt) max_cnt = obs_cnt;
      if (obs_gnt != '0 && prev_gnt == '0 && n_grants < 8) begin
        order[n_grants] = obs_gnt;
        n_grants++;
      end
      prev_gnt = obs_gnt;
    end
    n_tests++;
    if (n_grants != 5) begin
      n_fail++;
      $display("FAIL fair_grant_count: got %0d grants, required 5", n_grants);
    end else begin
      for (int g = 0; g < 5; g++) begin
        n_tests++;
        if (order[g] !== exp_order[g]) begin
          n_fail++;
          $display("FAIL fair_order[%0d]: gnt=%b, required %b", g, order[g], exp_order[g]);
        end
      end
    end
    n_tests++;
    if (idle_cnt != 5 || winc_cnt != 20) begin
      n_fail++;
      $display("FAIL fair_bubbles: idle=%0d writes=%0d, required 5/20", idle_cnt, winc_cnt);
    end
    n_tests++;
    if (max_cnt !== CW'(MAX_BURST-1)) begin
      n_fail++;
      $display("FAIL fair_burst_cnt_max: got %0d, required %0d", max_cnt, MAX_BURST-1);
    end
    cycle();
    n_tests++;
    if (obs_busy !== 1'b0 || obs_cnt !== '0) begin
      n_fail++;
      $display("FAIL fair_end_idle: busy=%b cnt=%0d, required 0/0", obs_busy, obs_cnt);
    end
    check_sb_empty("fair");
  endtask

  // Entered with rr_ptr=1: requester 3 wins over 0, then 0.
  task automatic test_rr_wrap();
    logic [NREQ-1:0] g1, g3;
    clear_queues();
    put(3, 8'h3C, 1'b1);
    put(0, 8'h0C, 1'b1);
    expect_word(3, 8'h3C);
    expect_word(0, 8'h0C);
    drive();
    cycle();
    cycle(); g1 = obs_gnt;
    cycle();
    cycle(); g3 = obs_gnt;
    cycle();
    n_tests++;
    if (g1 !== 4'b1000 || g3 !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_wrap_order: grants %b,%b, required 1000,0001", g1, g3);
    end
    check_sb_empty("rr_wrap");
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g [5];
    logic            w [5];
    logic [NREQ-1:0] ga, gb;
    clear_queues();
    put(1, 8'hA0, 1'b0);
    put(1, 8'hA1, 1'b0);
    put(1, 8'hA2, 1'b1);
    expect_word(1, 8'hA0);
    expect_word(1, 8'hA1);
    expect_word(1, 8'hA2);
    drive();
    for (int c = 0; c < 5; c++) begin
      cycle();
      g[c] = obs_gnt;
      w[c] = obs_winc;
    end
    n_tests++;
    if (g[0] !== 4'b0000 || g[1] !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_latency: gnt c0=%b c1=%b, required 0000,0010", g[0], g[1]);
    end
    n_tests++;
    if ({w[0], w[1], w[2], w[3], w[4]} !== 5'b01110) begin
      n_fail++;
      $display("FAIL single_winc: pattern %b%b%b%b%b, required 01110", w[0], w[1], w[2], w[3], w[4]);
    end
    n_tests++;
    if (g[4] !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b, required 0000", g[4]);
    end
    check_sb_empty("single");
    // rr_ptr is now 2: with 1 and 2 requesting, 2 must win.
    clear_queues();
    put(1, 8'hB1, 1'b1);
    put(2, 8'hB2, 1'b1);
    expect_word(2, 8'hB2);
    expect_word(1, 8'hB1);
    drive();
    cycle();
    cycle(); ga = obs_gnt;
    cycle();
    cycle(); gb = obs_gnt;
    cycle();
    n_tests++;
    if (ga !== 4'b0100 || gb !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_rr_ptr: grants %b,%b, required 0100,0010", ga, gb);
    end
    check_sb_empty("single_rr");
  endtask

  // Entered with rr_ptr=2; reset mid-burst must return arbitration to 0.
  task automatic test_reset_mid_burst();
    logic [NREQ-1:0] g;
    clear_queues();
    for (int k = 0; k < 4; k++) put(2, DSIZE'(8'hC0 + k), (k == 3));
    put(0, 8'hD0, 1'b0);
    put(0, 8'hD1, 1'b1);
    expect_word(2, 8'hC0);
    expect_word(2, 8'hC1);
    expect_word(0, 8'hD0);
    expect_word(0, 8'hD1);
    expect_word(2, 8'hC2);
    expect_word(2, 8'hC3);
    drive();
    cycle();
    cycle();
    cycle();
    wrst = 1'b1;
    cycle();
    n_tests++;
    if (obs_winc !== 1'b0 || obs_cnt !== CW'(2) || obs_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL rstmid_gate: winc=%b cnt=%0d gnt=%b, required 0/2/0100", obs_winc, obs_cnt, obs_gnt);
    end
    wrst = 1'b0;
    cycle();
    n_tests++;
    if (obs_gnt !== '0 || obs_cnt !== '0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: gnt=%b cnt=%0d busy=%b, required 0000/0/0", obs_gnt, obs_cnt, obs_busy);
    end
    cycle();
    g = obs_gnt;
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_rearb: gnt=%b, required 0001", g);
    end
    for (int c = 0; c < 5; c++) cycle();
    check_sb_empty("rstmid");
  endtask

  // Entered with rr_ptr=3: requester 3 sends one word and drops its request.
  task automatic test_owner_drop();
    logic [NREQ-1:0] g_drop, g_idle, g_next;
    logic            w_drop;
    clear_queues();
    put(3, 8'hE3, 1'b0);
    put(1, 8'hE1, 1'b1);
    expect_word(3, 8'hE3);
    expect_word(1, 8'hE1);
    drive();
    cycle();
    cycle();
    cycle(); w_drop = obs_winc; g_drop = obs_gnt;
    cycle(); g_idle = obs_gnt;
    cycle(); g_next = obs_gnt;
    cycle();
    n_tests++;
    if (w_drop !== 1'b0 || g_drop !== 4'b1000) begin
      n_fail++;
      $display("FAIL drop_no_extra: winc=%b gnt=%b, required 0/1000", w_drop, g_drop);
    end
    n_tests++;
    if (g_idle !== 4'b0000 || g_next !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_next_grant: gnt %b,%b, required 0000,0010", g_idle, g_next);
    end
    check_sb_empty("drop");
  endtask

  // Entered with rr_ptr=2: wfull stalls the second word of a 4-word burst.
  task automatic test_wfull_stall();
    int stall_bad;
    int winc_cnt;
    clear_queues();
    for (int k = 0; k < 4; k++) put(2, DSIZE'(8'hF0 + k), 1'b0);
    for (int k = 0; k < 4; k++) expect_word(2, DSIZE'(8'hF0 + k));
    drive();
    winc_cnt = 0;
    cycle();
    cycle(); if (obs_winc) winc_cnt++;
    wfull = 1'b1;
    stall_bad = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (obs_winc) winc_cnt++;
      if (obs_winc !== 1'b0 || obs_ack !== '0 || obs_gnt !== 4'b0100 ||
          obs_cnt !== CW'(1) || obs_wdata !== 8'hF1) stall_bad++;
    end
    n_tests++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL wfull_stall: %0d bad stall cycles (last winc=%b ack=%b gnt=%b cnt=%0d wdata=%h), required 0",
               stall_bad, obs_winc, obs_ack, obs_gnt, obs_cnt, obs_wdata);
    end
    wfull = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (obs_winc) winc_cnt++;
    end
    n_tests++;
    if (winc_cnt != 4 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wfull_total: writes=%0d busy=%b, required 4/0", winc_cnt, obs_busy);
    end
    check_sb_empty("wfull");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req      = '0;
    req_data = '0;
    req_last = '0;
    test_reset();
    test_fairness();
    test_rr_wrap();
    test_single();
    test_reset_mid_burst();
    test_owner_drop();
    test_wfull_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side scheduler for the asynchronous FIFO. It shares the single FIFO write port among NREQ requesters in the write clock domain, using round-robin arbitration with a bounded burst length. It drives winc and wdata into the FIFO write logic and obeys the wfull flag from that logic, so no write is ever issued while the FIFO is full.

Parameters:
NREQ, 4, number of requesters (≥2)
DSIZE, 8, FIFO data width in bits
MAX_BURST, 4, maximum words per grant before forced re-arbitration (≥1)
IW, $clog2(NREQ), requester index width
CW, $clog2(MAX_BURST+1), burst counter width

Ports:
wclk  in  1  write-domain clock; all logic on its rising edge
wrst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester write request; a requester holds it while it has data
req_data  in  NREQ*DSIZE  flattened per-requester data; slice i is [i*DSIZE +: DSIZE]
req_last  in  NREQ  requester i marks its current word as the final word of its packet
wfull  in  1  FIFO full flag (write domain)
gnt  out  NREQ  one-hot owner of the write port; registered
ack  out  NREQ  word from requester i accepted this cycle; combinational
winc  out  1  FIFO write increment
wdata  out  DSIZE  FIFO write data = req_data slice of the current owner
busy  out  1  high while in BURST
burst_cnt  out  CW  words written in the current grant; registered

Behaviour:
- Reset (wrst high at a wclk edge): state=IDLE, gnt=0, owner=0, rr_ptr=0, burst_cnt=0. winc and ack are gated by !wrst, so they are 0 during any cycle where wrst is high, including a reset asserted mid-burst. A partially sent packet is abandoned; the requester re-requests.
- States are IDLE and BURST.
- IDLE: if req≠0, select the first set bit scanning from rr_ptr upward with wrap modulo NREQ. At the next edge: owner←selected, gnt←onehot(owner), burst_cnt←0, state←BURST. Arbitration latency is 1 cycle from req to gnt. If req=0, stay in IDLE.
- BURST: winc = req[owner] & !wfull & !wrst. ack[owner]=winc; all other ack bits are 0. wdata is the owner slice in every BURST cycle, regardless of winc.
- On winc: burst_cnt increments. The burst ends when req_last[owner] is high, or when burst_cnt==MAX_BURST-1.
- Burst end (winc with end condition), or req[owner] low: at the next edge state←IDLE, gnt←0, burst_cnt←0, rr_ptr←(owner+1) mod NREQ. This leaves one idle bubble between grants.
- wfull high in BURST: stall. State, gnt and burst_cnt hold, winc=0. There is no timeout; the owner keeps the port until space appears.
- wfull rising in the same cycle as a would-be write: no write occurs. wfull is sampled combinationally, so no overflow is possible.
- req bits of non-owners are ignored during BURST. Requests arriving in IDLE in the same cycle are resolved only by rr_ptr order.
- The owner dropping req mid-burst without req_last ends the grant. No error is flagged.
- busy = (state==BURST).
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NREQ-1,0. Each grant writes at most MAX_BURST words.

Decomposition:
- Shared package fifo_pkg holds:
  - the state enum (IDLE=1'b0, BURST=1'b1)
  - default DSIZE
  - a function onehot(idx)
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req[NREQ], rr_ptr[IW].
  - Outputs: valid, idx[IW].
  - Implemented as a double-width masked priority encoder.
  - Reused by the future read-side scheduler.

Test Plan:
1. Single requester: req=4'b0010, data 0xA0..0xA2, req_last on 3rd word, wfull=0 → gnt=4'b0010 one cycle after req; winc high 3 consecutive cycles; wdata sequence A0,A1,A2; then IDLE; rr_ptr=2.
2. All requesters active, never last, MAX_BURST=4 → grant order 0,1,2,3,0. Each grant writes exactly 4 words. One bubble cycle between grants; burst_cnt reaches 3 then clears.
3. wfull asserted on the 2nd word of a burst for 5 cycles → winc=0 and ack=0 for those 5 cycles; gnt and burst_cnt=1 held; the write resumes with the same word after wfull drops; total words = 4.
4. wrst pulsed for 1 cycle mid-burst (burst_cnt=2) → winc=0 in the reset cycle; next cycle gnt=0, burst_cnt=0, state IDLE; re-arbitration starts from requester 0.
5. Owner drops req after 1 word with req_last=0 → grant ends; the next grant goes to the next requesting index after the owner; no extra winc.
6. req=4'b1001 with rr_ptr=1 → requester 3 is granted first, then requester 0.
